// File: rtl/chip8_alu_sequencer.sv
// CHIP-8 8XYN register-register ALU sequencer.
// Accepts one 8XYN instruction at a time. It reads Vx and Vy through the
// register file's two registered read ports and computes the result. It
// then writes Vx and, for flag-producing ops, VF through the single write
// port.
module chip8_alu_sequencer #(
    parameter bit VF_RESET_QUIRK = 1'b0,
    parameter bit SHIFT_USE_VY   = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] opcode,
    output logic        busy,
    output logic        done,
    output logic        illegal,
    output logic [3:0]  rf_select_output1,
    output logic [3:0]  rf_select_output2,
    input  logic [7:0]  rf_output1_data,
    input  logic [7:0]  rf_output2_data,
    output logic        rf_write_enable,
    output logic [3:0]  rf_select_input,
    output logic [7:0]  rf_input_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_WB_X,
        S_WB_F,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  x_q, x_d;
    logic [3:0]  y_q, y_d;
    logic [3:0]  n_q, n_d;
    logic        illegal_q, illegal_d;
    logic [7:0]  result_q, result_d;
    logic        flag_q, flag_d;

    logic        opLegal;
    logic        writesFlag;
    logic [7:0]  aluR;
    logic        aluF;
    logic [7:0]  shiftSrc;
    logic [8:0]  sum;

    // Decode whether the incoming instruction word is a supported 8XYN op.
    always_comb begin
        opLegal = 1'b0;
        if (opcode[15:12] == 4'h8) begin
            case (opcode[3:0])
                4'h0, 4'h1, 4'h2, 4'h3, 4'h4,
                4'h5, 4'h6, 4'h7, 4'hE: opLegal = 1'b1;
                default:                opLegal = 1'b0;
            endcase
        end
    end

    // Ops 4-7 and E always update VF; the logic ops do so only under the quirk.
    always_comb begin
        case (n_q)
            4'h1, 4'h2, 4'h3:              writesFlag = VF_RESET_QUIRK;
            4'h4, 4'h5, 4'h6, 4'h7, 4'hE:  writesFlag = 1'b1;
            default:                       writesFlag = 1'b0;
        endcase
    end

    // Combinational ALU on the read-port data that is valid during EXEC.
    always_comb begin
        shiftSrc = SHIFT_USE_VY ? rf_output2_data : rf_output1_data;
        sum      = {1'b0, rf_output1_data} + {1'b0, rf_output2_data};
        aluR     = 8'h00;
        aluF     = 1'b0;
        case (n_q)
            4'h0: aluR = rf_output2_data;
            4'h1: aluR = rf_output1_data | rf_output2_data;
            4'h2: aluR = rf_output1_data & rf_output2_data;
            4'h3: aluR = rf_output1_data ^ rf_output2_data;
            4'h4: begin
                aluR = sum[7:0];
                aluF = sum[8];
            end
            4'h5: begin
                aluR = rf_output1_data - rf_output2_data;
                aluF = (rf_output1_data >= rf_output2_data);
            end
            4'h6: begin
                aluR = {1'b0, shiftSrc[7:1]};
                aluF = shiftSrc[0];
            end
            4'h7: begin
                aluR = rf_output2_data - rf_output1_data;
                aluF = (rf_output2_data >= rf_output1_data);
            end
            4'hE: begin
                aluR = {shiftSrc[6:0], 1'b0};
                aluF = shiftSrc[7];
            end
            default: begin
                aluR = 8'h00;
                aluF = 1'b0;
            end
        endcase
    end

    // Next-state logic: sequence READ, EXEC, writeback(s), DONE.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        n_d       = n_q;
        illegal_d = illegal_q;
        result_d  = result_q;
        flag_d    = flag_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d       = opcode[11:8];
                    y_d       = opcode[7:4];
                    n_d       = opcode[3:0];
                    illegal_d = ~opLegal;
                    state_d   = opLegal ? S_READ : S_DONE;
                end
            end
            S_READ: state_d = S_EXEC;
            S_EXEC: begin
                result_d = aluR;
                flag_d   = aluF;
                state_d  = S_WB_X;
            end
            S_WB_X: state_d = writesFlag ? S_WB_F : S_DONE;
            S_WB_F: state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and latched-instruction registers; reset drops any pending write.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            x_q       <= 4'h0;
            y_q       <= 4'h0;
            n_q       <= 4'h0;
            illegal_q <= 1'b0;
            result_q  <= 8'h00;
            flag_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            n_q       <= n_d;
            illegal_q <= illegal_d;
            result_q  <= result_d;
            flag_q    <= flag_d;
        end
    end

    // Outputs are decoded from the current state so no write leaks outside WB_X/WB_F.
    always_comb begin
        busy              = 1'b0;
        done              = 1'b0;
        illegal           = 1'b0;
        rf_select_output1 = 4'h0;
        rf_select_output2 = 4'h0;
        rf_write_enable   = 1'b0;
        rf_select_input   = 4'h0;
        rf_input_data     = 8'h00;
        case (state_q)
            S_READ, S_EXEC: begin
                busy              = 1'b1;
                rf_select_output1 = x_q;
                rf_select_output2 = y_q;
            end
            S_WB_X: begin
                busy            = 1'b1;
                rf_write_enable = 1'b1;
                rf_select_input = x_q;
                rf_input_data   = result_q;
            end
            S_WB_F: begin
                busy            = 1'b1;
                rf_write_enable = 1'b1;
                rf_select_input = 4'hF;
                rf_input_data   = {7'b0, flag_q};
            end
            S_DONE: begin
                done    = 1'b1;
                illegal = illegal_q;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_chip8_alu_sequencer.sv
// Self-checking bench for chip8_alu_sequencer with a behavioural register file.
module tb_chip8_alu_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] opcode;
    logic        busy;
    logic        done;
    logic        illegal;
    logic [3:0]  rf_select_output1;
    logic [3:0]  rf_select_output2;
    logic [7:0]  rf_output1_data;
    logic [7:0]  rf_output2_data;
    logic        rf_write_enable;
    logic [3:0]  rf_select_input;
    logic [7:0]  rf_input_data;

    int checks = 0;
    int errors = 0;

    logic [7:0] regs [16];

    typedef struct packed {
        logic [3:0] sel;
        logic [7:0] data;
    } wr_t;

    wr_t expWrites[$];

    typedef struct {
        logic [15:0] op;
        logic [7:0]  va;
        logic [7:0]  vb;
        logic [7:0]  expR;
        logic        expF;
        logic        flagWr;
        logic        ill;
        int          cycles;
    } vec_t;

    vec_t vecs [13];

    chip8_alu_sequencer #(
        .VF_RESET_QUIRK(1'b0),
        .SHIFT_USE_VY(1'b0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .opcode(opcode),
        .busy(busy),
        .done(done),
        .illegal(illegal),
        .rf_select_output1(rf_select_output1),
        .rf_select_output2(rf_select_output2),
        .rf_output1_data(rf_output1_data),
        .rf_output2_data(rf_output2_data),
        .rf_write_enable(rf_write_enable),
        .rf_select_input(rf_select_input),
        .rf_input_data(rf_input_data)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural register file: registered reads on both ports, writes at posedge.
    always @(posedge clk) begin
        rf_output1_data <= regs[rf_select_output1];
        rf_output2_data <= regs[rf_select_output2];
        if (rf_write_enable) regs[rf_select_input] <= rf_input_data;
    end

    // Scoreboard: every observed write must match the oldest expected write.
    always @(negedge clk) begin
        if (rf_write_enable) begin
            checks++;
            if (expWrites.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpectedWrite: got sel=%h data=%h, required no write",
                         rf_select_input, rf_input_data);
            end else begin
                wr_t w;
                w = expWrites.pop_front();
                if (rf_select_input !== w.sel || rf_input_data !== w.data) begin
                    errors++;
                    $display("[TB] FAIL writeData: got sel=%h data=%h, required sel=%h data=%h",
                             rf_select_input, rf_input_data, w.sel, w.data);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] op);
        @(negedge clk);
        start  = 1'b1;
        opcode = op;
        @(posedge clk);
        #1;
        start  = 1'b0;
        opcode = 16'($urandom);
    endtask

    task automatic waitDone(output int cyc, output logic ill, output logic busyFirst);
        cyc       = 0;
        ill       = 1'b0;
        busyFirst = 1'b0;
        while (cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) busyFirst = busy;
            if (done) begin
                ill = illegal;
                break;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL doneTimeout: got no done within %0d cycles, required done", cyc);
        end
    endtask

    task automatic preload(input logic [3:0] x, input logic [3:0] y, input logic [7:0] va, input logic [7:0] vb);
        @(negedge clk);
        regs[4'hF] = 8'h5A;
        regs[y]    = vb;
        regs[x]    = va;
    endtask

    initial begin
        int          cyc;
        logic        ill;
        logic        busyFirst;
        logic [3:0]  x;
        logic [3:0]  y;
        logic [7:0]  expX;
        logic [7:0]  expVF;

        vecs[0]  = '{16'h8124, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b1, 1'b0, 5};
        vecs[1]  = '{16'h8125, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b1, 1'b0, 5};
        vecs[2]  = '{16'h8125, 8'h20, 8'h20, 8'h00, 1'b1, 1'b1, 1'b0, 5};
        vecs[3]  = '{16'h8F14, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 5};
        vecs[4]  = '{16'h8106, 8'h81, 8'h33, 8'h40, 1'b1, 1'b1, 1'b0, 5};
        vecs[5]  = '{16'h8121, 8'h0F, 8'hF0, 8'hFF, 1'b0, 1'b0, 1'b0, 4};
        vecs[6]  = '{16'h8127, 8'h30, 8'h10, 8'hE0, 1'b0, 1'b1, 1'b0, 5};
        vecs[7]  = '{16'h812E, 8'h81, 8'h7F, 8'h02, 1'b1, 1'b1, 1'b0, 5};
        vecs[8]  = '{16'h8120, 8'h11, 8'h99, 8'h99, 1'b0, 1'b0, 1'b0, 4};
        vecs[9]  = '{16'h8122, 8'h3C, 8'h0F, 8'h0C, 1'b0, 1'b0, 1'b0, 4};
        vecs[10] = '{16'h8123, 8'hFF, 8'h0F, 8'hF0, 1'b0, 1'b0, 1'b0, 4};
        vecs[11] = '{16'h8128, 8'h44, 8'h55, 8'h44, 1'b0, 1'b0, 1'b1, 1};
        vecs[12] = '{16'h9124, 8'h66, 8'h77, 8'h66, 1'b0, 1'b0, 1'b1, 1};

        for (int i = 0; i < 16; i++) regs[i] = 8'h00;
        reset  = 1'b1;
        start  = 1'b0;
        opcode = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("resetState",
                    {19'b0, busy, done, illegal, rf_write_enable, rf_select_output1,
                     rf_select_output2, rf_select_input},
                    32'h0);
        checkOutput("resetData", {24'b0, rf_input_data}, 32'h0);
        reset = 1'b0;

        // Table-driven single instructions.
        for (int i = 0; i < 13; i++) begin
            x = vecs[i].op[11:8];
            y = vecs[i].op[7:4];
            preload(x, y, vecs[i].va, vecs[i].vb);
            if (!vecs[i].ill) begin
                expWrites.push_back('{x, vecs[i].expR});
                if (vecs[i].flagWr) expWrites.push_back('{4'hF, {7'b0, vecs[i].expF}});
            end
            applyStimulus(vecs[i].op);
            waitDone(cyc, ill, busyFirst);
            checkOutput($sformatf("latency[%0d]", i), cyc, vecs[i].cycles);
            checkOutput($sformatf("illegal[%0d]", i), {31'b0, ill}, {31'b0, vecs[i].ill});
            checkOutput($sformatf("busyFirst[%0d]", i), {31'b0, busyFirst}, {31'b0, ~vecs[i].ill});
            expX  = vecs[i].ill ? vecs[i].va : vecs[i].expR;
            expVF = vecs[i].flagWr ? {7'b0, vecs[i].expF} : 8'h5A;
            if (x != 4'hF) checkOutput($sformatf("vx[%0d]", i), {24'b0, regs[x]}, {24'b0, expX});
            checkOutput($sformatf("vf[%0d]", i), {24'b0, regs[4'hF]}, {24'b0, expVF});
            checkOutput($sformatf("pending[%0d]", i), expWrites.size(), 0);
        end

        // Start pulses while busy must be ignored and not queued.
        preload(4'h1, 4'h2, 8'h20, 8'h20);
        expWrites.push_back('{4'h1, 8'h00});
        expWrites.push_back('{4'hF, 8'h01});
        applyStimulus(16'h8125);
        cyc = 0;
        while (cyc < 20 && !done) begin
            @(negedge clk);
            cyc++;
            start  = (cyc <= 3);
            opcode = 16'h8F14;
        end
        start = 1'b0;
        checkOutput("busyStartLatency", cyc, 5);
        repeat (3) @(negedge clk);
        checkOutput("busyStartIdle", {31'b0, busy}, 32'h0);
        checkOutput("busyStartV1", {24'b0, regs[1]}, 32'h00);
        checkOutput("busyStartVF", {24'b0, regs[4'hF]}, 32'h01);
        checkOutput("busyStartPending", expWrites.size(), 0);

        // Reset during WB_X drops the pending VF write.
        preload(4'h1, 4'h2, 8'hF0, 8'h20);
        regs[4'hF] = 8'h55;
        expWrites.push_back('{4'h1, 8'h10});
        applyStimulus(16'h8124);
        repeat (3) @(negedge clk);
        checkOutput("wbxReached", {31'b0, rf_write_enable}, 32'h1);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("resetMidBusy", {29'b0, busy, done, rf_write_enable}, 32'h0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("resetMidVF", {24'b0, regs[4'hF]}, 32'h55);
        checkOutput("resetMidPending", expWrites.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
